weight_bank_loader: RTL
=======================

// Module: weight_bank_loader
// PURPOSE
//   Consumer end of the weight pipeline control interface. Takes the per-MAC
//   weight_ctrl enable mask and a valid/ready weight stream. Writes one weight
//   word into each enabled MAC slot, in ascending index order.
//   Slots outside the mask keep their weights, so the LAYER half computes
//   while the LOAD half refills. Sits between the weight source and the MAC array.
// PARAMETERS
//   N_MACS   4  number of MAC weight slots; equals weight_ctrl width
//   DATA_W   8  width of one weight word
// PORTS
//   clk          in   1               clock
//   rst          in   1               reset, asynchronous, active-high
//   weight_ctrl  in   N_MACS          per-MAC load-enable mask from pipeline ctrl
//   w_valid      in   1               weight beat valid
//   w_data       in   DATA_W          weight beat data
//   w_ready      out  1               loader accepts beat this cycle
//   weight_out   out  N_MACS*DATA_W   slot i at bits [i*DATA_W +: DATA_W]
//   weight_vld   out  N_MACS          slot i holds a weight written under the current load
//   load_done    out  1               1-cycle pulse: last masked slot written
//   loading      out  1               high while in FILL
// BEHAVIOUR
//   Reset: state=IDLE, cur_mask=0, ptr=0, weight_out=0, weight_vld=0,
//     load_done=0, loading=0. w_ready=0 during and after reset.
//   Registered state: cur_mask (captured mask), ptr (slot index,
//     clog2(N_MACS) bits, min 1).
//   Outputs: w_ready = (state==FILL), combinational. loading = (state==FILL).
//   States:
//     IDLE : weight_ctrl!=0 -> capture cur_mask=weight_ctrl;
//            clear weight_vld bits in the mask; ptr = lowest set bit; go FILL.
//     FILL : on w_valid&&w_ready, write w_data into slot ptr and set weight_vld[ptr].
//            Then ptr = next set bit of cur_mask above ptr.
//            If ptr was the highest set bit: go DONE, load_done=1 next cycle.
//     DONE : hold until weight_ctrl != cur_mask.
//            New mask 0 -> IDLE, cur_mask=0. New mask nonzero -> re-capture as in IDLE.
//   Beat latency: beat accepted at edge k appears on weight_out and weight_vld after edge k.
//   Boundary cases:
//     - weight_ctrl->0 mid-FILL: abort to IDLE next edge. A beat presented that
//       cycle is still accepted (w_ready is based on current state). Partial
//       vld bits stay; unwritten masked slots stay invalid.
//     - weight_ctrl changes to another nonzero value mid-FILL: restart with the
//       new mask. Clear the new mask's vld bits and set ptr to its lowest bit.
//       A beat accepted that same cycle is discarded.
//     - Single-bit mask: one beat, then DONE. Full mask: N_MACS beats.
//     - Slots outside cur_mask: weight_out and weight_vld never change.
//     - w_valid while not in FILL: ignored, no stall, no write.
//     - rst mid-FILL: immediate return to reset values, all weights cleared.
// STRUCTURE
//   Shared package weight_pkg: state encodings (IDLE/FILL/DONE) and ctrl mode
//     codes (0 idle, 1 load, 2 layer), shared with the pipeline controller.
//   One sub-module: wbl_next_bit, combinational. Inputs: mask, ptr, find_first.
//     Outputs: next set-bit index and a last flag. Used for ptr init and advance.
// TESTING  (N_MACS=4, DATA_W=8)
//   1. ctrl=4'b0011, beats 0xA1,0xB2 back-to-back -> slot0=A1, slot1=B2,
//      vld=0011, load_done pulses once on the cycle after the 2nd beat, w_ready then 0.
//   2. Preload slots 2,3 = 0x33,0x44, then ctrl=4'b0011 load -> slots 2,3 unchanged
//      throughout. Then ctrl=4'b1100 -> vld[3:2] clear, new beats fill 2 then 3.
//   3. w_valid toggling 1,0,1,0 in FILL with mask 0101 -> writes only on valid
//      cycles; slot0 then slot2; load_done after 2 accepted beats.
//   4. ctrl 0011->0 after one beat -> IDLE, vld=0001, later beats ignored
//      (w_ready=0), no load_done.
//   5. ctrl 0011->1100 mid-FILL with a beat in the same cycle -> beat dropped,
//      ptr=2, next beat lands in slot2.
//   6. Assert rst mid-FILL -> same cycle weight_out=0, vld=0, w_ready=0, load_done=0.

Source files
------------

// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared weight pipeline state and control mode encodings
package weight_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } wbl_state_t;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_LOAD  = 2'd1,
      MODE_LAYER = 2'd2
   } ctrl_mode_t;

endpackage

// File: rtl/wbl_next_bit.sv
// rtl/wbl_next_bit.sv - finds lowest set mask bit, or next set bit above ptr
module wbl_next_bit
   import weight_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_mask,
   input  logic [PW-1:0] i_ptr,
   input  logic          i_find_first,
   output logic [PW-1:0] o_idx,
   output logic          o_last
);

   logic w_found;

   // o_last: no qualifying set bit exists, i.e. i_ptr was the highest one
   always_comb begin
      w_found = 1'b0;
      o_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && i_mask[i] && (i_find_first || (PW'(i) > i_ptr))) begin
            w_found = 1'b1;
            o_idx   = PW'(i);
         end
      end
      o_last = !w_found;
   end

endmodule

// File: rtl/weight_bank_loader.sv
// rtl/weight_bank_loader.sv - writes one streamed weight into each masked MAC slot in ascending order
module weight_bank_loader
   import weight_pkg::*;
#(
   parameter int N_MACS = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_MACS-1:0]        weight_ctrl,
   input  logic                     w_valid,
   input  logic [DATA_W-1:0]        w_data,
   output logic                     w_ready,
   output logic [N_MACS*DATA_W-1:0] weight_out,
   output logic [N_MACS-1:0]        weight_vld,
   output logic                     load_done,
   output logic                     loading
);

   localparam int PW = (N_MACS > 1) ? $clog2(N_MACS) : 1;

   wbl_state_t        r_state, w_state_nx;
   logic [N_MACS-1:0] r_mask, w_mask_nx;
   logic [PW-1:0]     r_ptr, w_ptr_nx;
   logic [DATA_W-1:0] r_slot [N_MACS];
   logic [DATA_W-1:0] w_slot_nx [N_MACS];
   logic [N_MACS-1:0] r_vld, w_vld_nx;
   logic              r_done, w_done_nx;

   logic              w_find_first;
   logic [N_MACS-1:0] w_search_mask;
   logic [PW-1:0]     w_idx;
   logic              w_last;
   logic              w_accept;

   // Outside an unchanged-mask FILL we always search the incoming mask from bit 0
   assign w_find_first  = (r_state != ST_FILL) || (weight_ctrl != r_mask);
   assign w_search_mask = w_find_first ? weight_ctrl : r_mask;

   wbl_next_bit #(.N(N_MACS), .PW(PW)) u_next_bit (
      .i_mask       (w_search_mask),
      .i_ptr        (r_ptr),
      .i_find_first (w_find_first),
      .o_idx        (w_idx),
      .o_last       (w_last)
   );

   assign w_ready   = (r_state == ST_FILL);
   assign loading   = (r_state == ST_FILL);
   assign load_done = r_done;
   assign weight_vld = r_vld;
   assign w_accept  = w_valid && w_ready;

   for (genvar g = 0; g < N_MACS; g++) begin : g_out
      assign weight_out[g*DATA_W +: DATA_W] = r_slot[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_mask  <= '0;
         r_ptr   <= '0;
         r_vld   <= '0;
         r_done  <= 1'b0;
         for (int i = 0; i < N_MACS; i++) r_slot[i] <= '0;
      end else begin
         r_state <= w_state_nx;
         r_mask  <= w_mask_nx;
         r_ptr   <= w_ptr_nx;
         r_vld   <= w_vld_nx;
         r_done  <= w_done_nx;
         for (int i = 0; i < N_MACS; i++) r_slot[i] <= w_slot_nx[i];
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_mask_nx  = r_mask;
      w_ptr_nx   = r_ptr;
      w_vld_nx   = r_vld;
      w_done_nx  = 1'b0;
      for (int i = 0; i < N_MACS; i++) w_slot_nx[i] = r_slot[i];

      case (r_state)
         ST_IDLE: begin
            if (weight_ctrl != '0) begin
               w_mask_nx  = weight_ctrl;
               w_vld_nx   = r_vld & ~weight_ctrl;
               w_ptr_nx   = w_idx;
               w_state_nx = ST_FILL;
            end
         end
         ST_FILL: begin
            if (weight_ctrl == '0) begin
               // Abort still honours a beat handshaken this cycle
               if (w_accept) begin
                  w_slot_nx[r_ptr] = w_data;
                  w_vld_nx[r_ptr]  = 1'b1;
               end
               w_mask_nx  = '0;
               w_ptr_nx   = '0;
               w_state_nx = ST_IDLE;
            end else if (weight_ctrl != r_mask) begin
               w_mask_nx  = weight_ctrl;
               w_vld_nx   = r_vld & ~weight_ctrl;
               w_ptr_nx   = w_idx;
            end else if (w_accept) begin
               w_slot_nx[r_ptr] = w_data;
               w_vld_nx[r_ptr]  = 1'b1;
               if (w_last) begin
                  w_state_nx = ST_DONE;
                  w_done_nx  = 1'b1;
               end else begin
                  w_ptr_nx = w_idx;
               end
            end
         end
         ST_DONE: begin
            if (weight_ctrl == '0) begin
               w_mask_nx  = '0;
               w_ptr_nx   = '0;
               w_state_nx = ST_IDLE;
            end else if (weight_ctrl != r_mask) begin
               w_mask_nx  = weight_ctrl;
               w_vld_nx   = r_vld & ~weight_ctrl;
               w_ptr_nx   = w_idx;
               w_state_nx = ST_FILL;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

endmodule
